// File: rtl/tank_motion_ctl.sv
// -----------------------------------------------------------------------------
// tank_motion_ctl
//
// Purpose:
//   Per-frame position scheduler for the tank sprite path. On each rising edge
//   of vertical blank it runs a short four-state sequence
//   (IDLE -> CALC -> CLAMP -> COMMIT). The sequence produces the tank's next
//   top-left position and move direction. All outputs are registered and only
//   change in COMMIT, so the draw stage never sees a position change
//   mid-frame.
//
//   Local mode (SelectMode=0): keyboard levels move the tank by STEP pixels
//   per frame. Priority is up > down > left > right, one axis per frame.
//   Remote mode (SelectMode=1): a one-entry pending buffer fed by a
//   valid/ready link supplies absolute coordinates. If the buffer is empty,
//   the position is held.
//
// Optional feature (compile-time macro TANK_MOTION_ACCEL_EN):
//   When defined, a 4-bit hold counter tracks consecutive frames that use the
//   same direction key. Once the counter saturates at 15, the step doubles.
//   When undefined, the step is always STEP.
//
// Ports:
//   clk           in   pixel clock
//   rst           in   synchronous active-high reset
//   vblnk         in   vertical blank from timing chain
//   SelectMode    in   0 = local keyboard, 1 = remote
//   key_up/down/left/right  in  move requests (levels)
//   remote_x/y    in   [9:0] remote coordinates
//   remote_valid  in   remote coordinate valid
//   remote_ready  out  remote coordinate accepted when valid && ready
//   xpos/ypos     out  [11:0] tank position
//   dir           out  [1:0] last move direction: 0 up, 1 down, 2 left, 3 right
//   Select_out    out  SelectMode latched at commit
//   frame_done    out  one-cycle pulse after a new position is committed
// -----------------------------------------------------------------------------
module tank_motion_ctl #(
    parameter int X_INIT = 100,
    parameter int Y_INIT = 400,
    parameter int STEP   = 2,
    parameter int X_MAX  = 800,
    parameter int Y_MAX  = 600,
    parameter int TANK_W = 64,
    parameter int TANK_H = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        SelectMode,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_left,
    input  logic        key_right,
    input  logic [9:0]  remote_x,
    input  logic [9:0]  remote_y,
    input  logic        remote_valid,
    output logic        remote_ready,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [1:0]  dir,
    output logic        Select_out,
    output logic        frame_done
);

    // Highest legal top-left coordinate on each axis.
    localparam logic [11:0] X_LIM   = 12'(X_MAX - TANK_W);
    localparam logic [11:0] Y_LIM   = 12'(Y_MAX - TANK_H);
    localparam logic [11:0] X_RST   = 12'(X_INIT);
    localparam logic [11:0] Y_RST   = 12'(Y_INIT);
    localparam logic [11:0] STEP_1X = 12'(STEP);
`ifdef TANK_MOTION_ACCEL_EN
    localparam logic [11:0] STEP_2X = 12'(2 * STEP);
`endif

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_CLAMP,
        S_COMMIT
    } state_t;

    state_t      r_state;
    logic        r_vblnk_q;

    // Committed (output) state
    logic [11:0] r_xpos;
    logic [11:0] r_ypos;
    logic [1:0]  r_dir;
    logic        r_sel_out;
    logic        r_frame_done;

    // One-entry remote coordinate buffer
    logic        r_pend_full;
    logic [9:0]  r_pend_x;
    logic [9:0]  r_pend_y;

    // Candidate carried from CALC through CLAMP to COMMIT
    logic [11:0] r_cand_x;
    logic [11:0] r_cand_y;
    logic [1:0]  r_cand_dir;
    logic        r_cand_hit;   // a local key moved the tank this frame
    logic        r_cand_sel;

`ifdef TANK_MOTION_ACCEL_EN
    logic [3:0]  r_hold_cnt;
    logic [1:0]  r_prev_dir;
    logic        r_prev_hit;
`endif

    logic        w_frame_start;
    logic        w_ready;
    logic        w_accept;
    logic        w_key_hit;
    logic [1:0]  w_key_dir;
    logic [11:0] w_step;
    logic [11:0] w_cand_x;
    logic [11:0] w_cand_y;

    assign w_frame_start = vblnk && !r_vblnk_q;
    // Ready stays low in COMMIT, so an accept can never race the buffer clear.
    assign w_ready       = !r_pend_full && (r_state != S_COMMIT);
    assign w_accept      = remote_valid && w_ready;

    assign w_key_hit = key_up || key_down || key_left || key_right;

    always_comb begin
        w_key_dir = DIR_RIGHT;
        if (key_up)
            w_key_dir = DIR_UP;
        else if (key_down)
            w_key_dir = DIR_DOWN;
        else if (key_left)
            w_key_dir = DIR_LEFT;
    end

`ifdef TANK_MOTION_ACCEL_EN
    assign w_step = (r_hold_cnt == 4'd15) ? STEP_2X : STEP_1X;
`else
    assign w_step = STEP_1X;
`endif

    // Unclamped candidate for the current frame. Subtraction floors at zero
    // instead of wrapping; addition overflow is handled by the CLAMP stage.
    always_comb begin
        w_cand_x = r_xpos;
        w_cand_y = r_ypos;
        if (SelectMode) begin
            if (r_pend_full) begin
                w_cand_x = {2'b00, r_pend_x};
                w_cand_y = {2'b00, r_pend_y};
            end
        end else if (w_key_hit) begin
            case (w_key_dir)
                DIR_UP:    w_cand_y = (r_ypos < w_step) ? 12'd0 : (r_ypos - w_step);
                DIR_DOWN:  w_cand_y = r_ypos + w_step;
                DIR_LEFT:  w_cand_x = (r_xpos < w_step) ? 12'd0 : (r_xpos - w_step);
                default:   w_cand_x = r_xpos + w_step;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_vblnk_q    <= 1'b0;
            r_xpos       <= X_RST;
            r_ypos       <= Y_RST;
            r_dir        <= DIR_UP;
            r_sel_out    <= 1'b0;
            r_frame_done <= 1'b0;
            r_pend_full  <= 1'b0;
            r_pend_x     <= 10'd0;
            r_pend_y     <= 10'd0;
            r_cand_x     <= X_RST;
            r_cand_y     <= Y_RST;
            r_cand_dir   <= DIR_UP;
            r_cand_hit   <= 1'b0;
            r_cand_sel   <= 1'b0;
`ifdef TANK_MOTION_ACCEL_EN
            r_hold_cnt   <= 4'd0;
            r_prev_dir   <= DIR_UP;
            r_prev_hit   <= 1'b0;
`endif
        end else begin
            r_vblnk_q    <= vblnk;
            r_frame_done <= 1'b0;

            if (w_accept) begin
                r_pend_full <= 1'b1;
                r_pend_x    <= remote_x;
                r_pend_y    <= remote_y;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_frame_start)
                        r_state <= S_CALC;
                end

                S_CALC: begin
                    r_cand_x   <= w_cand_x;
                    r_cand_y   <= w_cand_y;
                    r_cand_dir <= w_key_dir;
                    r_cand_hit <= !SelectMode && w_key_hit;
                    r_cand_sel <= SelectMode;
                    r_state    <= S_CLAMP;
                end

                S_CLAMP: begin
                    if (r_cand_x > X_LIM)
                        r_cand_x <= X_LIM;
                    if (r_cand_y > Y_LIM)
                        r_cand_y <= Y_LIM;
                    r_state <= S_COMMIT;
                end

                S_COMMIT: begin
                    r_xpos       <= r_cand_x;
                    r_ypos       <= r_cand_y;
                    r_sel_out    <= r_cand_sel;
                    r_frame_done <= 1'b1;
                    if (r_cand_hit)
                        r_dir <= r_cand_dir;
                    // Consumed in remote mode, stale in local mode: either
                    // way the entry is gone after this frame.
                    r_pend_full  <= 1'b0;
`ifdef TANK_MOTION_ACCEL_EN
                    if (r_cand_hit) begin
                        if (r_prev_hit && (r_prev_dir == r_cand_dir)) begin
                            if (r_hold_cnt != 4'd15)
                                r_hold_cnt <= r_hold_cnt + 4'd1;
                        end else begin
                            r_hold_cnt <= 4'd0;
                        end
                        r_prev_hit <= 1'b1;
                        r_prev_dir <= r_cand_dir;
                    end else begin
                        // Key release or remote mode breaks the streak.
                        r_hold_cnt <= 4'd0;
                        r_prev_hit <= 1'b0;
                    end
`endif
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign remote_ready = w_ready;
    assign xpos         = r_xpos;
    assign ypos         = r_ypos;
    assign dir          = r_dir;
    assign Select_out   = r_sel_out;
    assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_tank_motion_ctl.sv
// -----------------------------------------------------------------------------
// tb_tank_motion_ctl
//
// Table-driven bench for tank_motion_ctl. Each table record describes one
// frame: the mode, the held keys, an optional remote coordinate sent before
// the frame, and the expected committed position, direction and mode.
// Hand-written sequences cover reset values and reset in the middle of a
// frame sequence.
// -----------------------------------------------------------------------------
module tb_tank_motion_ctl;

    logic        clk;
    logic        rst;
    logic        vblnk;
    logic        SelectMode;
    logic        key_up;
    logic        key_down;
    logic        key_left;
    logic        key_right;
    logic [9:0]  remote_x;
    logic [9:0]  remote_y;
    logic        remote_valid;
    logic        remote_ready;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic [1:0]  dir;
    logic        Select_out;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    tank_motion_ctl dut (
        .clk          (clk),
        .rst          (rst),
        .vblnk        (vblnk),
        .SelectMode   (SelectMode),
        .key_up       (key_up),
        .key_down     (key_down),
        .key_left     (key_left),
        .key_right    (key_right),
        .remote_x     (remote_x),
        .remote_y     (remote_y),
        .remote_valid (remote_valid),
        .remote_ready (remote_ready),
        .xpos         (xpos),
        .ypos         (ypos),
        .dir          (dir),
        .Select_out   (Select_out),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit sel;
        bit u, d, l, r;
        bit send;
        int rx, ry;
        int ex, ey, ed;
        bit es;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit sel, bit u, bit d, bit l, bit r,
                                bit send, int rx, int ry,
                                int ex, int ey, int ed, bit es);
        vec_t v;
        v.sel = sel; v.u = u; v.d = d; v.l = l; v.r = r;
        v.send = send; v.rx = rx; v.ry = ry;
        v.ex = ex; v.ey = ey; v.ed = ed; v.es = es;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Send one remote coordinate through the valid/ready link.
    task automatic send_remote(int rx, int ry);
        @(negedge clk);
        check("ready_before_send", int'(remote_ready), 1);
        remote_x     = 10'(rx);
        remote_y     = 10'(ry);
        remote_valid = 1'b1;
        @(negedge clk);
        remote_valid = 1'b0;
        check("ready_after_accept", int'(remote_ready), 0);
    endtask

    // Raise vblnk and watch a bounded window. The window records when
    // frame_done fires (cycles after the sampling edge), how long it stays
    // high, and what ready looks like while the FSM sits in COMMIT.
    task automatic run_frame(output int lat, output int width, output int rdy_commit);
        @(negedge clk);
        vblnk = 1'b1;
        lat = -1;
        width = 0;
        rdy_commit = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (frame_done) begin
                width++;
                if (lat < 0) lat = c;
            end
            if (c == 2) rdy_commit = int'(remote_ready);
        end
        vblnk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int lat, width, rdy, fd_seen;

        // ---------------- stimulus table ----------------
        // start: x=100 y=400 dir=0
        for (int i = 0; i < 3; i++) add(0, 0,0,0,0, 0,0,0, 100, 400, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 0,0,0,1, 0,0,0, 102 + 2*i, 400, 3, 0);
        add(0, 1,1,0,0, 0,0,0,      120, 398, 0, 0);  // up+down -> up
        add(0, 1,1,0,0, 0,0,0,      120, 396, 0, 0);
        add(0, 0,1,1,0, 0,0,0,      120, 398, 1, 0);  // down beats left
        add(0, 0,0,1,1, 0,0,0,      118, 398, 2, 0);  // left beats right
        add(0, 0,0,0,0, 0,0,0,      118, 398, 2, 0);  // no key: hold
        add(1, 0,0,0,0, 1,1,300,      1, 300, 2, 1);  // remote to x=1
        add(0, 0,0,1,0, 0,0,0,        0, 300, 2, 0);  // left from 1 -> 0
        add(0, 0,0,1,0, 0,0,0,        0, 300, 2, 0);  // left at 0 stays 0
        add(1, 0,0,0,0, 1,734,10,   734,  10, 2, 1);
        add(0, 0,0,0,1, 0,0,0,      736,  10, 3, 0);  // right 734 -> 736
        add(0, 0,0,0,1, 0,0,0,      736,  10, 3, 0);  // clamped
        add(0, 1,0,0,0, 0,0,0,      736,   8, 0, 0);
        add(1, 0,0,0,0, 1,900,20,   736,  20, 0, 1);  // remote x clamped
        add(1, 0,0,0,0, 0,0,0,      736,  20, 0, 1);  // empty buffer: hold
        add(0, 0,1,0,0, 1,50,50,    736,  22, 1, 0);  // pending dropped
        add(1, 0,0,0,0, 0,0,0,      736,  22, 1, 1);  // confirms drop
        add(1, 1,0,0,0, 1,1023,1023, 736, 552, 1, 1); // keys ignored remote
        add(0, 1,0,0,0, 0,0,0,      736, 550, 0, 0);
        add(1, 0,0,0,0, 1,5,1,        5,   1, 0, 1);
        add(0, 1,0,0,0, 0,0,0,        5,   0, 0, 0);  // up from 1 -> 0
        add(0, 0,1,0,0, 0,0,0,        5,   2, 1, 0);

        // ---------------- reset ----------------
        rst = 1'b1; vblnk = 1'b0; SelectMode = 1'b0;
        key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;
        remote_x = '0; remote_y = '0; remote_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_xpos", int'(xpos), 100);
        check("rst_ypos", int'(ypos), 400);
        check("rst_dir", int'(dir), 0);
        check("rst_sel", int'(Select_out), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_ready", int'(remote_ready), 1);

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            SelectMode = vecs[i].sel;
            key_up     = vecs[i].u;
            key_down   = vecs[i].d;
            key_left   = vecs[i].l;
            key_right  = vecs[i].r;
            if (vecs[i].send) send_remote(vecs[i].rx, vecs[i].ry);
            run_frame(lat, width, rdy);
            $display("frame %0d sel=%0d keys=%0d%0d%0d%0d -> x=%0d y=%0d dir=%0d sel_out=%0d lat=%0d",
                     i, vecs[i].sel, vecs[i].u, vecs[i].d, vecs[i].l, vecs[i].r,
                     xpos, ypos, dir, Select_out, lat);
            check("latency", lat, 3);
            check("pulse_width", width, 1);
            check("ready_in_commit", rdy, 0);
            check("xpos", int'(xpos), vecs[i].ex);
            check("ypos", int'(ypos), vecs[i].ey);
            check("dir", int'(dir), vecs[i].ed);
            check("select_out", int'(Select_out), int'(vecs[i].es));
            check("ready_after_frame", int'(remote_ready), 1);
        end

        // ---------------- reset during CLAMP with a pending entry ----------
        SelectMode = 1'b0;
        key_up = 1'b0; key_down = 1'b1; key_left = 1'b0; key_right = 1'b0;
        send_remote(300, 300);
        @(negedge clk);
        vblnk = 1'b1;
        @(negedge clk);          // sampled edge passed: CALC
        @(negedge clk);          // CLAMP
        rst = 1'b1;
        vblnk = 1'b0;
        @(negedge clk);
        $display("reset-in-clamp -> x=%0d y=%0d dir=%0d ready=%0d", xpos, ypos, dir, remote_ready);
        check("clamp_rst_xpos", int'(xpos), 100);
        check("clamp_rst_ypos", int'(ypos), 400);
        check("clamp_rst_dir", int'(dir), 0);
        check("clamp_rst_frame_done", int'(frame_done), 0);
        check("clamp_rst_ready", int'(remote_ready), 1);
        rst = 1'b0;
        fd_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (frame_done) fd_seen++;
        end
        check("no_commit_after_rst", fd_seen, 0);

        // Pending entry must be gone: a remote frame holds the reset position.
        SelectMode = 1'b1;
        key_down = 1'b0;
        run_frame(lat, width, rdy);
        $display("post-reset remote frame -> x=%0d y=%0d sel_out=%0d lat=%0d", xpos, ypos, Select_out, lat);
        check("post_rst_latency", lat, 3);
        check("post_rst_xpos", int'(xpos), 100);
        check("post_rst_ypos", int'(ypos), 400);
        check("post_rst_sel", int'(Select_out), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
